ldpc_3gpp_dec_cnode_c2v_engine: RTL and testbench

LDPC_3GPP_DEC_CNODE_C2V_ENGINE -- requirements
Module: ldpc_3gpp_dec_cnode_c2v_engine

---
 rtl/ldpc_3gpp_dec_cnode_c2v_engine.sv | 136 +++++++++++++
 tb/tb_ldpc_3gpp_dec_cnode_c2v_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_3gpp_dec_cnode_c2v_engine.sv
// Check-node c2v engine: expands a stored min-sum row summary (min1/min2/sign)
// into one signed c2v message per requested column, with a two-stage pipeline.
module ldpc_3gpp_dec_cnode_c2v_engine #(
    parameter int pLLR_W  = 4,
    parameter int pNODE_W = 5,
    parameter int pNORM   = 1
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      iclkena,
    input  logic                      iload,
    input  logic [pLLR_W-2:0]         imin1,
    input  logic [pLLR_W-2:0]         imin2,
    input  logic [pNODE_W-1:0]        imin1_col,
    input  logic                      isign_prod,
    input  logic [pNODE_W-1:0]        ideg,
    input  logic                      ival,
    input  logic [pNODE_W-1:0]        icol,
    input  logic                      ivn_sign,
    output logic                      ordy,
    output logic                      oval,
    output logic [pNODE_W-1:0]        ocol,
    output logic signed [pLLR_W-1:0]  oc2v,
    output logic                      odone,
    output logic                      oerr
);

    localparam int cMAG_W = pLLR_W - 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state;
    logic [pNODE_W-1:0]   remain;
    logic [cMAG_W-1:0]    min1;
    logic [cMAG_W-1:0]    min2;
    logic [pNODE_W-1:0]   min1_col;
    logic                 sign_prod;

    logic                 s1_val;
    logic                 s1_sgn;
    logic                 s1_last;
    logic [cMAG_W-1:0]    s1_mag;
    logic [pNODE_W-1:0]   s1_col;

    logic                 accept;
    logic                 last_req;
    logic [cMAG_W-1:0]    nmag;
    logic [pLLR_W-1:0]    pmag;

    assign accept   = (state == ACTIVE) && ival;
    assign last_req = (remain == pNODE_W'(1));
    assign ordy     = (state == IDLE);

    // Requests outside ACTIVE and loads outside IDLE are protocol errors.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state     <= IDLE;
            remain    <= '0;
            min1      <= '0;
            min2      <= '0;
            min1_col  <= '0;
            sign_prod <= 1'b0;
            oerr      <= 1'b0;
        end else if (iclkena) begin
            case (state)
                IDLE: begin
                    if (ival) begin
                        oerr <= 1'b1;
                    end
                    if (iload) begin
                        if (ideg == '0) begin
                            oerr <= 1'b1;
                        end else begin
                            min1      <= imin1;
                            min2      <= imin2;
                            min1_col  <= imin1_col;
                            sign_prod <= isign_prod;
                            remain    <= ideg;
                            state     <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (iload) begin
                        oerr <= 1'b1;
                    end
                    if (ival) begin
                        remain <= remain - pNODE_W'(1);
                        if (last_req) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            s1_val  <= 1'b0;
            s1_sgn  <= 1'b0;
            s1_last <= 1'b0;
            s1_mag  <= '0;
            s1_col  <= '0;
        end else if (iclkena) begin
            s1_val <= accept;
            if (accept) begin
                s1_mag  <= (icol == min1_col) ? min2 : min1;
                s1_sgn  <= sign_prod ^ ivn_sign;
                s1_col  <= icol;
                s1_last <= last_req;
            end
        end
    end

    // 0.75 scaling as mag - mag/4 keeps the result within the magnitude width.
    assign nmag = (pNORM == 0) ? s1_mag : s1_mag - (s1_mag >> 2);
    assign pmag = {1'b0, nmag};

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval  <= 1'b0;
            odone <= 1'b0;
            ocol  <= '0;
            oc2v  <= '0;
        end else if (iclkena) begin
            oval  <= s1_val;
            odone <= s1_val & s1_last;
            if (s1_val) begin
                ocol <= s1_col;
                oc2v <= $signed(s1_sgn ? (-pmag) : pmag);
            end
        end
    end

endmodule

// File: tb/tb_ldpc_3gpp_dec_cnode_c2v_engine.sv
// Bench for the c2v engine: two instances (plain and normalized) share stimulus;
// directed vector table, corner sequences and a randomized scoreboard run.
module tb_ldpc_3gpp_dec_cnode_c2v_engine;

    localparam int LLR_W  = 5;
    localparam int NODE_W = 5;

    logic              iclk = 1'b0;
    logic              ireset = 1'b1;
    logic              iclkena = 1'b1;
    logic              iload = 1'b0;
    logic [LLR_W-2:0]  imin1 = '0;
    logic [LLR_W-2:0]  imin2 = '0;
    logic [NODE_W-1:0] imin1_col = '0;
    logic              isign_prod = 1'b0;
    logic [NODE_W-1:0] ideg = '0;
    logic              ival = 1'b0;
    logic [NODE_W-1:0] icol = '0;
    logic              ivn_sign = 1'b0;

    logic              ordy0, oval0, odone0, oerr0;
    logic              ordy1, oval1, odone1, oerr1;
    logic [NODE_W-1:0] ocol0, ocol1;
    logic signed [LLR_W-1:0] oc2v0, oc2v1;

    int n_checks = 0;
    int n_fail   = 0;

    ldpc_3gpp_dec_cnode_c2v_engine #(.pLLR_W(LLR_W), .pNODE_W(NODE_W), .pNORM(0)) dut0 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iload(iload),
        .imin1(imin1), .imin2(imin2), .imin1_col(imin1_col), .isign_prod(isign_prod),
        .ideg(ideg), .ival(ival), .icol(icol), .ivn_sign(ivn_sign),
        .ordy(ordy0), .oval(oval0), .ocol(ocol0), .oc2v(oc2v0), .odone(odone0), .oerr(oerr0)
    );

    ldpc_3gpp_dec_cnode_c2v_engine #(.pLLR_W(LLR_W), .pNODE_W(NODE_W), .pNORM(1)) dut1 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iload(iload),
        .imin1(imin1), .imin2(imin2), .imin1_col(imin1_col), .isign_prod(isign_prod),
        .ideg(ideg), .ival(ival), .icol(icol), .ivn_sign(ivn_sign),
        .ordy(ordy1), .oval(oval1), .ocol(ocol1), .oc2v(oc2v1), .odone(odone1), .oerr(oerr1)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int due;
        int col;
        int mag;
        bit sgn;
        bit last;
    } exp_t;

    typedef struct {
        bit ld; int deg; int m1; int m2; int mc; bit sp;
        bit v; int c; bit vs;
        bit x_oval; int x_col; int x_c2v0; int x_c2v1; bit x_done; bit x_rdy;
    } vec_t;

    exp_t q[$];
    bit   m_active = 0;
    int   m_rem = 0;
    int   m_min1 = 0, m_min2 = 0, m_col = 0;
    bit   m_sp = 0;
    bit   m_err = 0;
    int   encnt = 0;
    bit   last_en = 0;

    function automatic int ref_c2v(int mag, bit sgn, bit norm);
        int nm;
        nm = norm ? (3 * mag + 3) / 4 : mag;
        return sgn ? -nm : nm;
    endfunction

    task automatic check(string name, int actual, int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: row summary, remaining count and a queue of due outputs.
    initial begin
        forever begin
            @(posedge iclk or posedge ireset);
            if (ireset) begin
                m_active = 0; m_rem = 0; m_err = 0; encnt = 0; last_en = 0;
                q.delete();
            end else begin
                last_en = iclkena;
                if (iclkena) begin
                    encnt++;
                    if (!m_active) begin
                        if (ival) m_err = 1;
                        if (iload) begin
                            if (ideg == 0) m_err = 1;
                            else begin
                                m_min1 = imin1; m_min2 = imin2; m_col = imin1_col;
                                m_sp = isign_prod; m_rem = ideg; m_active = 1;
                            end
                        end
                    end else begin
                        if (iload) m_err = 1;
                        if (ival) begin
                            exp_t e;
                            e.due  = encnt + 1;
                            e.col  = icol;
                            e.mag  = (int'(icol) == m_col) ? m_min2 : m_min1;
                            e.sgn  = m_sp ^ ivn_sign;
                            e.last = (m_rem == 1);
                            q.push_back(e);
                            m_rem--;
                            if (m_rem == 0) m_active = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic scoreboard_check();
        exp_t e;
        bit   xv = 0;
        if (q.size() > 0 && q[0].due == encnt) begin
            xv = 1;
            e = q.pop_front();
        end
        check("sb_oval0", oval0, xv);
        check("sb_oval1", oval1, xv);
        check("sb_odone0", odone0, xv && e.last);
        check("sb_odone1", odone1, xv && e.last);
        if (xv) begin
            check("sb_ocol0", ocol0, e.col);
            check("sb_ocol1", ocol1, e.col);
            check("sb_c2v0", oc2v0, ref_c2v(e.mag, e.sgn, 0));
            check("sb_c2v1", oc2v1, ref_c2v(e.mag, e.sgn, 1));
        end
        check("sb_ordy", ordy0, !m_active);
        check("sb_oerr0", oerr0, m_err);
        check("sb_oerr1", oerr1, m_err);
    endtask

    initial begin
        forever begin
            @(negedge iclk);
            if (!ireset && last_en) scoreboard_check();
        end
    end

    task automatic drive(bit ld, int deg, int m1, int m2, int mc, bit sp, bit v, int c, bit vs);
        iload = ld; ideg = deg[NODE_W-1:0];
        imin1 = m1[LLR_W-2:0]; imin2 = m2[LLR_W-2:0]; imin1_col = mc[NODE_W-1:0];
        isign_prod = sp; ival = v; icol = c[NODE_W-1:0]; ivn_sign = vs;
    endtask

    task automatic idle();
        iload = 0; ival = 0;
    endtask

    task automatic step();
        @(negedge iclk);
    endtask

    task automatic apply_stimulus(vec_t t);
        drive(t.ld, t.deg, t.m1, t.m2, t.mc, t.sp, t.v, t.c, t.vs);
    endtask

    task automatic check_output(vec_t t, int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        check({s, "_oval0"}, oval0, t.x_oval);
        check({s, "_oval1"}, oval1, t.x_oval);
        check({s, "_odone0"}, odone0, t.x_done);
        check({s, "_ordy"}, ordy0, t.x_rdy);
        check({s, "_oerr"}, oerr0, 0);
        if (t.x_oval) begin
            check({s, "_ocol"}, ocol0, t.x_col);
            check({s, "_c2v0"}, oc2v0, t.x_c2v0);
            check({s, "_c2v1"}, oc2v1, t.x_c2v1);
        end
    endtask

    task automatic check_reset_values(string s);
        check({s, "_oval"}, oval0 | oval1, 0);
        check({s, "_odone"}, odone0 | odone1, 0);
        check({s, "_oerr"}, oerr0 | oerr1, 0);
        check({s, "_ocol"}, ocol0 | ocol1, 0);
        check({s, "_c2v0"}, oc2v0, 0);
        check({s, "_c2v1"}, oc2v1, 0);
        check({s, "_ordy"}, ordy0 & ordy1, 1);
    endtask

    vec_t tbl[13];

    initial begin
        //          ld deg m1 m2 mc sp  v  c vs | oval col c2v0 c2v1 done rdy
        tbl[0]  = '{1, 3,  3, 9, 4, 0, 0, 0, 0,  0, 0,   0,   0, 0, 0};
        tbl[1]  = '{0, 0,  0, 0, 0, 0, 1, 2, 0,  0, 0,   0,   0, 0, 0};
        tbl[2]  = '{0, 0,  0, 0, 0, 0, 1, 4, 1,  1, 2,   3,   3, 0, 0};
        tbl[3]  = '{0, 0,  0, 0, 0, 0, 1, 7, 0,  1, 4,  -9,  -7, 0, 1};
        tbl[4]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 7,   3,   3, 1, 1};
        tbl[5]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0,   0,   0, 0, 1};
        tbl[6]  = '{1, 1, 15,15, 0, 1, 0, 0, 0,  0, 0,   0,   0, 0, 0};
        tbl[7]  = '{0, 0,  0, 0, 0, 0, 1, 3, 0,  0, 0,   0,   0, 0, 1};
        tbl[8]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 3, -15, -12, 1, 1};
        tbl[9]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0,   0,   0, 0, 1};
        tbl[10] = '{1, 1,  0, 5, 1, 1, 0, 0, 0,  0, 0,   0,   0, 0, 0};
        tbl[11] = '{0, 0,  0, 0, 0, 0, 1, 2, 0,  0, 0,   0,   0, 0, 1};
        tbl[12] = '{0, 0,  0, 0, 0, 0, 0, 0, 0,  1, 2,   0,   0, 1, 1};

        step();
        check_reset_values("reset");
        step();
        ireset = 0;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(tbl[i]);
            step();
            check_output(tbl[i], i);
        end

        // A zero-degree load is refused and flagged.
        drive(1, 0, 3, 4, 1, 0, 0, 0, 0);
        step();
        check("deg0_ordy", ordy0, 1);
        check("deg0_oerr", oerr0, 1);
        idle();
        step();
        check("deg0_oval", oval0, 0);

        ireset = 1; step(); ireset = 0;
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        check("idle_req_oerr", oerr0, 1);
        idle();
        step();
        check("idle_req_oval", oval0, 0);
        drive(1, 2, 2, 6, 3, 0, 0, 0, 0);
        step();
        check("err_load_ordy", ordy0, 0);
        drive(1, 4, 7, 8, 5, 1, 1, 3, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 5, 0);
        step();
        check("err_c2v0_a", oc2v0, 6);
        check("err_c2v1_a", oc2v1, 5);
        check("err_ordy", ordy0, 1);
        idle();
        step();
        check("err_c2v0_b", oc2v0, 2);
        check("err_done_b", odone0, 1);
        check("err_sticky", oerr1, 1);
        step();
        check("err_sticky2", oerr0, 1);

        // Clock-enable freeze between acceptance and output.
        ireset = 1; step(); ireset = 0;
        drive(1, 1, 5, 10, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 6, 1);
        step();
        iclkena = 0;
        drive(1, 0, 0, 0, 0, 0, 1, 9, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("frz_oval", oval0, 0);
            check("frz_oerr", oerr0, 0);
        end
        iclkena = 1;
        idle();
        step();
        check("frz_out_oval", oval0, 1);
        check("frz_out_col", ocol0, 6);
        check("frz_out_c2v0", oc2v0, -5);
        check("frz_out_c2v1", oc2v1, -4);
        check("frz_out_done", odone1, 1);
        iclkena = 0;
        step();
        check("frz_hold_oval", oval1, 1);
        check("frz_hold_c2v", oc2v0, -5);
        iclkena = 1;
        step();
        check("frz_after_oval", oval0, 0);

        // Reset with two requests in flight.
        drive(1, 3, 4, 8, 2, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 2, 1);
        step();
        idle();
        ireset = 1;
        #1;
        check_reset_values("midrst");
        step();
        ireset = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("midrst_oval", oval0 | oval1, 0);
            check("midrst_ordy", ordy0, 1);
        end

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 500; n++) begin
            int m1, m2;
            m1 = $urandom_range(15);
            m2 = $urandom_range(15, m1);
            iclkena = ($urandom_range(7) != 0);
            drive(m_active ? ($urandom_range(31) == 0) : ($urandom_range(2) == 0),
                  ($urandom_range(15) == 0) ? 0 : $urandom_range(6, 1),
                  m1, m2, $urandom_range(7), $urandom_range(1),
                  m_active ? ($urandom_range(3) != 0) : ($urandom_range(31) == 0),
                  $urandom_range(7), $urandom_range(1));
            step();
        end
        iclkena = 1;
        idle();
        for (int k = 0; k < 4; k++) step();
        check("drain_pending", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
